// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: writeback-source select and FSM state.
// Pure types, no logic.
package hazard_pkg;

    typedef enum logic [1:0] {
        ALU_RES = 2'b00,
        PC_ADD4 = 2'b01,
        MEM_RD  = 2'b10,
        IMM     = 2'b11
    } wd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_fwd_port.sv
// One EX read port's bypass: picks MEM (non-load) over WB, flags a MEM load hit.
// Purely combinational; no backpressure of its own.
module hazard_fwd_port
    import hazard_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          i_re,
    input  logic [AW-1:0] i_ra,
    input  logic          i_we_mem,
    input  logic [AW-1:0] i_wa_mem,
    input  wd_sel_e       i_wd_sel_mem,
    input  logic [DW-1:0] i_alu_ans_mem,
    input  logic [DW-1:0] i_pc_add4_mem,
    input  logic [DW-1:0] i_imm_mem,
    input  logic          i_we_wb,
    input  logic [AW-1:0] i_wa_wb,
    input  logic [DW-1:0] i_wd_wb,
    output logic          o_fe,
    output logic [DW-1:0] o_fd,
    output logic          o_load_hit
);

    logic w_match_mem;
    logic w_match_wb;

    assign w_match_mem = i_re & i_we_mem & (i_wa_mem != '0) & (i_wa_mem == i_ra);
    assign w_match_wb  = i_re & i_we_wb  & (i_wa_wb  != '0) & (i_wa_wb  == i_ra);
    assign o_fe        = w_match_mem | w_match_wb;
    assign o_load_hit  = w_match_mem & (i_wd_sel_mem == MEM_RD);

    // Load data is not yet available in MEM, so a load hit falls through to WB.
    always_comb begin
        o_fd = '0;
        if (w_match_mem && (i_wd_sel_mem != MEM_RD)) begin
            case (i_wd_sel_mem)
                PC_ADD4: o_fd = i_pc_add4_mem;
                IMM:     o_fd = i_imm_mem;
                default: o_fd = i_alu_ans_mem;
            endcase
        end else if (w_match_wb) begin
            o_fd = i_wd_wb;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand bypass, load-use / memory-wait stalls, redirect flushes.
// Stall/flush/forward outputs are combinational; stall_cnt and mem_timeout are registered.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRP*AW-1:0] ra_ex,
    input  logic [NRP-1:0]    re_ex,
    input  logic              we_mem,
    input  logic [AW-1:0]     wa_mem,
    input  logic [1:0]        wd_sel_mem,
    input  logic [DW-1:0]     alu_ans_mem,
    input  logic [DW-1:0]     pc_add4_mem,
    input  logic [DW-1:0]     imm_mem,
    input  logic              we_wb,
    input  logic [AW-1:0]     wa_wb,
    input  logic [DW-1:0]     wd_wb,
    input  logic              redirect_ex,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic [NRP-1:0]    fe,
    output logic [NRP*DW-1:0] fd,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic [31:0]       stall_cnt,
    output logic              mem_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic          w_fe       [NRP];
    logic [DW-1:0] w_fd       [NRP];
    logic          w_load_hit [NRP];
    logic          w_load_use;
    logic          w_mem_wait;
    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic          r_mem_timeout;
    logic [31:0]   r_stall_cnt;

    for (genvar g = 0; g < NRP; g++) begin : g_port
        hazard_fwd_port #(.DW(DW), .AW(AW)) u_port (
            .i_re          (re_ex[g]),
            .i_ra          (ra_ex[g*AW +: AW]),
            .i_we_mem      (we_mem),
            .i_wa_mem      (wa_mem),
            .i_wd_sel_mem  (wd_sel_e'(wd_sel_mem)),
            .i_alu_ans_mem (alu_ans_mem),
            .i_pc_add4_mem (pc_add4_mem),
            .i_imm_mem     (imm_mem),
            .i_we_wb       (we_wb),
            .i_wa_wb       (wa_wb),
            .i_wd_wb       (wd_wb),
            .o_fe          (w_fe[g]),
            .o_fd          (w_fd[g]),
            .o_load_hit    (w_load_hit[g])
        );
    end

    always_comb begin
        fe         = '0;
        fd         = '0;
        w_load_use = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            fe[i]          = w_fe[i];
            fd[i*DW +: DW] = w_fd[i];
            w_load_use     = w_load_use | w_load_hit[i];
        end
    end

    assign w_mem_wait = mem_req & ~mem_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // Memory wait outranks load-use: the whole pipe freezes and nothing is bubbled.
    always_comb begin
        w_state_nxt = r_state;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        flush_mem   = 1'b0;
        case (r_state)
            RUN:      if (w_mem_wait) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ready)  w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
        if (w_mem_wait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (w_load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            flush_mem = 1'b1;
        end
        flush_id = redirect_ex & ~stall_ex;
        flush_ex = redirect_ex & ~stall_ex;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_state_nxt == RUN)
                r_wait_cnt <= '0;
            else if ((r_state == MEM_WAIT) && (r_wait_cnt != CW'(TIMEOUT)))
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if ((r_state == MEM_WAIT) && (r_wait_cnt >= CW'(TIMEOUT - 1)))
                r_mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (stall_if && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt   = r_stall_cnt;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DW, default 32, datapath width.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter NRP, default 2, number of EX-stage register read ports (1..4).
REQ-004 Parameter TIMEOUT, default 255, max MEM-wait cycles before error.
REQ-005 clk  in  1  clock; one clock domain, reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ra_ex  in  NRP*AW  EX read addresses, port i at bits [i*AW +: AW].
REQ-008 re_ex  in  NRP  EX read enables.
REQ-009 we_mem, wa_mem[AW], wd_sel_mem[2], alu_ans_mem[DW], pc_add4_mem[DW], imm_mem[DW]  in  MEM-stage writeback info.
REQ-010 we_wb, wa_wb[AW], wd_wb[DW]  in  WB-stage writeback info.
REQ-011 redirect_ex  in  1  EX resolved a taken jal/jalr/branch.
REQ-012 mem_req  in  1  MEM-stage access in progress.
REQ-013 mem_ready  in  1  memory completes access this cycle.
REQ-014 fe  out  NRP  per-port forward enable.
REQ-015 fd  out  NRP*DW  per-port forward data.
REQ-016 stall_if, stall_id, stall_ex, stall_mem  out  1 each  stage hold.
REQ-017 flush_id, flush_ex, flush_mem  out  1 each  stage bubble insert.
REQ-018 stall_cnt  out  32  saturating stall-cycle counter.
REQ-019 mem_timeout  out  1  sticky MEM-wait timeout error.

Function
REQ-020 Port i match_mem = re_ex[i] & we_mem & wa_mem!=0 & wa_mem==ra_i; match_wb analogous with WB signals.
REQ-021 fe[i] = match_mem | match_wb; register 0 never forwarded.
REQ-022 fd[i]: match_mem and wd_sel_mem!=MEM_RD -> ALU_RES alu_ans_mem, PC_ADD4 pc_add4_mem, IMM imm_mem; else match_wb -> wd_wb; else 0.
REQ-023 MEM priority over WB on double match; a MEM load match never forwards from MEM.
REQ-024 load_use = any port match_mem with wd_sel_mem==MEM_RD.
REQ-025 FSM states RUN, MEM_WAIT; RUN->MEM_WAIT when mem_req & !mem_ready; MEM_WAIT->RUN when mem_ready; otherwise hold.
REQ-026 mem_wait = mem_req & !mem_ready, combinational, valid in both states; all four stalls asserted, no flush.
REQ-027 load_use & !mem_wait -> stall_if/id/ex=1, stall_mem=0, flush_mem=1, for exactly the cycle(s) load_use holds.
REQ-028 mem_wait has priority over load_use: flush_mem=0 while mem_wait.
REQ-029 flush_id = flush_ex = redirect_ex & !stall_ex; redirect suppressed while EX held, honoured on release cycle.
REQ-030 Simultaneous redirect_ex and load_use: stall wins, no flush_id/flush_ex that cycle.
REQ-031 Wait counter (width clog2(TIMEOUT+1)) increments each MEM_WAIT cycle, clears on entry to RUN.
REQ-032 Counter reaching TIMEOUT sets mem_timeout; cleared only by rst; stall behaviour unchanged.
REQ-033 stall_cnt increments when stall_if=1, saturates at 0xFFFF_FFFF.
REQ-034 All outputs except stall_cnt, mem_timeout are combinational from current inputs and state.

Reset
REQ-035 rst: state RUN, wait counter 0, stall_cnt 0, mem_timeout 0, next cycle.
REQ-036 rst mid-MEM_WAIT returns to RUN; combinational stalls still follow mem_req/mem_ready.

Structure
REQ-037 Package hazard_pkg holds wd_sel encodings ALU_RES=00, PC_ADD4=01, MEM_RD=10, IMM=11 and the FSM state enum.
REQ-038 Sub-module hazard_fwd_port computes fe/fd for one port, instantiated NRP times in a generate loop.

Verification
REQ-039 MEM ALU wa=5 ans=0x11, WB wa=5 wd=0x22, ra0=5 re0=1 -> fe[0]=1, fd[0]=0x11.
REQ-040 MEM load wa=7, ra1=7 re1=1, mem_req=0 -> stall_if/id/ex=1, flush_mem=1 one cycle; next cycle WB wa=7 wd=0x33 -> fd[1]=0x33, no stall.
REQ-041 mem_req=1, mem_ready=0 for 3 cycles, redirect_ex=1 -> all stalls 1, flush_ex=0; 4th cycle mem_ready=1 -> flush_id=flush_ex=1, state RUN.
REQ-042 wa_mem=0, we_mem=1, ra0=0 re0=1 -> fe[0]=0, fd[0]=0, no stall.
REQ-043 TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after 4 MEM_WAIT cycles, stays 1 after mem_ready until rst.
REQ-044 stall_cnt preset near 0xFFFF_FFFE via 3 stall cycles -> saturates at 0xFFFF_FFFF.
